// File: rtl/mux_arb_pkg.sv
// Shared definitions for the two-requester round-robin mux arbiter:
// state encoding, default geometry and counter widths.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    localparam int unsigned DATA_W_DEF    = 8;
    localparam int unsigned MAX_BURST_DEF = 4;
    localparam int unsigned BURST_W       = 4;
    localparam int unsigned STATS_W       = 16;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester, output-bus and status signals of the mux arbiter.
// The slave modport is the arbiter side; master is the surrounding environment.
interface mux_rr_arbiter_if #(
    parameter int unsigned DATA_W = mux_arb_pkg::DATA_W_DEF
);
    logic              s0_valid;
    logic [DATA_W-1:0] s0_data;
    logic              s0_ready;
    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic              s1_ready;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;
    logic              sel;
    logic              busy;

    modport slave (
        input  s0_valid, s0_data, s1_valid, s1_data, m_ready,
        output s0_ready, s1_ready, m_valid, m_data, sel, busy
    );

    modport master (
        output s0_valid, s0_data, s1_valid, s1_data, m_ready,
        input  s0_ready, s1_ready, m_valid, m_data, sel, busy
    );
endinterface

// File: rtl/mux_out_reg.sv
// One-entry output register with valid/ready handshake; drains and refills
// in the same cycle so the stream runs at one beat per clock.
module mux_out_reg #(
    parameter int unsigned DATA_W = mux_arb_pkg::DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready_c,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    assign in_ready_c = !out_valid || out_ready;

    // Data is left in place after a drain; only out_valid marks it stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin arbiter driving a shared 2:1 mux into a registered
// output, with bounded bursts. Define MUX_RR_ARBITER_STATS_EN for per-requester beat counters.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux_rr_arbiter_if.slave      bus
`ifdef MUX_RR_ARBITER_STATS_EN
    ,
    output logic [STATS_W-1:0]   gnt_cnt0,
    output logic [STATS_W-1:0]   gnt_cnt1
`endif
);

    arb_state_e          state_q, state_d;
    logic                prio_q, prio_d;
    logic [BURST_W-1:0]  cnt_q, cnt_d;

    logic                slot_free_c;
    logic                own_sel_c;
    logic                own_busy_c;
    logic                own_valid_c;
    logic                other_valid_c;
    logic                accept_c;
    logic                burst_done_c;
    logic                release_c;
    logic [DATA_W-1:0]   mux_data_c;

    assign own_sel_c     = (state_q == ST_OWN1);
    assign own_busy_c    = (state_q != ST_IDLE);
    assign own_valid_c   = own_sel_c ? bus.s1_valid : bus.s0_valid;
    assign other_valid_c = own_sel_c ? bus.s0_valid : bus.s1_valid;
    assign mux_data_c    = own_sel_c ? bus.s1_data  : bus.s0_data;

    assign bus.s0_ready  = (state_q == ST_OWN0) && slot_free_c;
    assign bus.s1_ready  = (state_q == ST_OWN1) && slot_free_c;
    assign bus.sel       = own_sel_c;
    assign bus.busy      = own_busy_c;

    assign accept_c      = own_busy_c && own_valid_c && slot_free_c;
    assign burst_done_c  = accept_c && (cnt_q == BURST_W'(MAX_BURST - 1));
    assign release_c     = own_busy_c && (!own_valid_c || burst_done_c);

    // prio_q names the requester that wins a tie; a releasing owner hands it to the other side.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (bus.s0_valid && bus.s1_valid) begin
                    state_d = prio_q ? ST_OWN1 : ST_OWN0;
                end else if (bus.s0_valid) begin
                    state_d = ST_OWN0;
                end else if (bus.s1_valid) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (release_c) begin
                    cnt_d  = '0;
                    prio_d = !own_sel_c;
                    if (other_valid_c) begin
                        state_d = own_sel_c ? ST_OWN0 : ST_OWN1;
                    end else if (!own_valid_c) begin
                        state_d = ST_IDLE;
                    end
                end else if (accept_c) begin
                    cnt_d = cnt_q + BURST_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
        end
    end

    mux_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (accept_c),
        .in_data    (mux_data_c),
        .in_ready_c (slot_free_c),
        .out_valid  (bus.m_valid),
        .out_data   (bus.m_data),
        .out_ready  (bus.m_ready)
    );

`ifdef MUX_RR_ARBITER_STATS_EN
    // Accepted-beat counters per requester, sticking at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else if (accept_c) begin
            if (!own_sel_c && (gnt_cnt0 != '1)) begin
                gnt_cnt0 <= gnt_cnt0 + STATS_W'(1);
            end
            if (own_sel_c && (gnt_cnt1 != '1)) begin
                gnt_cnt1 <= gnt_cnt1 + STATS_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed vector table, hand sequences
// and randomized traffic against a behavioural scoreboard model.
module tb_mux_rr_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned MB = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mux_rr_arbiter_if #(.DATA_W(DW)) bus();

`ifdef MUX_RR_ARBITER_STATS_EN
    logic [15:0] gnt_cnt0;
    logic [15:0] gnt_cnt1;
`endif

    mux_rr_arbiter #(
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus)
`ifdef MUX_RR_ARBITER_STATS_EN
        ,
        .gnt_cnt0 (gnt_cnt0),
        .gnt_cnt1 (gnt_cnt1)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int         mo_owner;      // -1 none, else requester index
    int         mo_last;       // -1 nobody released yet, else last releasing owner
    int         mo_beats;      // beats taken in current grant
    logic [7:0] mo_q[$];       // beats accepted but not yet taken downstream
    int         st0, st1;
    bit         acc0, acc1;

    task automatic model_reset();
        mo_owner = -1;
        mo_last  = -1;
        mo_beats = 0;
        mo_q.delete();
        st0 = 0;
        st1 = 0;
    endtask

    function automatic bit exp_ready(input int who);
        return (mo_owner == who) && (mo_q.size() == 0 || bus.m_ready);
    endfunction

    task automatic model_check(input string tag);
        chk({tag, ".s0_ready"}, 32'(bus.s0_ready), 32'(exp_ready(0)));
        chk({tag, ".s1_ready"}, 32'(bus.s1_ready), 32'(exp_ready(1)));
        chk({tag, ".sel"},      32'(bus.sel),      32'(mo_owner == 1));
        chk({tag, ".busy"},     32'(bus.busy),     32'(mo_owner != -1));
        chk({tag, ".m_valid"},  32'(bus.m_valid),  32'(mo_q.size() != 0));
        if (mo_q.size() != 0)
            chk({tag, ".m_data"}, 32'(bus.m_data), 32'(mo_q[0]));
    endtask

    // Advance the model across the coming rising edge using the driven inputs.
    task automatic model_step();
        bit v[2];
        logic [7:0] d[2];
        bit acc;
        v[0] = bus.s0_valid; v[1] = bus.s1_valid;
        d[0] = bus.s0_data;  d[1] = bus.s1_data;
        acc0 = exp_ready(0) && v[0];
        acc1 = exp_ready(1) && v[1];
        acc  = acc0 || acc1;
        if (mo_q.size() != 0 && bus.m_ready) void'(mo_q.pop_front());
        if (acc) mo_q.push_back(d[mo_owner]);
        if (acc0 && st0 < 65535) st0++;
        if (acc1 && st1 < 65535) st1++;
        if (mo_owner == -1) begin
            mo_beats = 0;
            if (v[0] && v[1]) mo_owner = (mo_last == 0) ? 1 : 0;
            else if (v[0])    mo_owner = 0;
            else if (v[1])    mo_owner = 1;
        end else begin
            if (acc) mo_beats++;
            if (mo_beats == MB || !v[mo_owner]) begin
                mo_last  = mo_owner;
                mo_beats = 0;
                if (v[1 - mo_owner])    mo_owner = 1 - mo_owner;
                else if (!v[mo_owner])  mo_owner = -1;
            end
        end
    endtask

    task automatic apply(input logic s0v, input logic [7:0] s0d,
                         input logic s1v, input logic [7:0] s1d, input logic mr);
        @(negedge clk);
        bus.s0_valid = s0v; bus.s0_data = s0d;
        bus.s1_valid = s1v; bus.s1_data = s1d;
        bus.m_ready  = mr;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.s0_valid = 1'b0; bus.s0_data = '0;
        bus.s1_valid = 1'b0; bus.s1_data = '0;
        bus.m_ready  = 1'b0;
        #1;
        chk("rst.m_valid", 32'(bus.m_valid), 32'd0);
        chk("rst.m_data",  32'(bus.m_data),  32'd0);
        chk("rst.sel",     32'(bus.sel),     32'd0);
        chk("rst.busy",    32'(bus.busy),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       s0v; logic [7:0] s0d;
        logic       s1v; logic [7:0] s1d;
        logic       mr;
        logic       e_sel, e_busy, e_r0, e_r1, e_mv;
        logic [7:0] e_md;
    } vec_t;

    vec_t vt[12];

    initial begin
        logic [7:0] s1d;

        vt[0]  = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[1]  = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        vt[2]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5};
        vt[3]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
        vt[4]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5};
        vt[5]  = '{1'b1, 8'h11, 1'b1, 8'h23, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22};
        vt[6]  = '{1'b1, 8'h11, 1'b1, 8'h23, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22};
        vt[7]  = '{1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h23};
        vt[8]  = '{1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h23};
        vt[9]  = '{1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h23};
        vt[10] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11};
        vt[11] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11};

        rst_n = 1'b0;
        bus.s0_valid = 1'b0; bus.s0_data = '0;
        bus.s1_valid = 1'b0; bus.s1_data = '0;
        bus.m_ready  = 1'b0;
        model_reset();

        do_reset();
        for (int i = 0; i < 12; i++) begin
            apply(vt[i].s0v, vt[i].s0d, vt[i].s1v, vt[i].s1d, vt[i].mr);
            chk($sformatf("vec%0d.sel", i),      32'(bus.sel),      32'(vt[i].e_sel));
            chk($sformatf("vec%0d.busy", i),     32'(bus.busy),     32'(vt[i].e_busy));
            chk($sformatf("vec%0d.s0_ready", i), 32'(bus.s0_ready), 32'(vt[i].e_r0));
            chk($sformatf("vec%0d.s1_ready", i), 32'(bus.s1_ready), 32'(vt[i].e_r1));
            chk($sformatf("vec%0d.m_valid", i),  32'(bus.m_valid),  32'(vt[i].e_mv));
            chk($sformatf("vec%0d.m_data", i),   32'(bus.m_data),   32'(vt[i].e_md));
        end

        // Both requesters streaming: 4 beats each, alternating, no bubble.
        do_reset();
        for (int k = 0; k < 18; k++) begin
            apply(1'b1, 8'h00, 1'b1, 8'h80, 1'b1);
            if (k >= 1) chk($sformatf("burst%0d.busy", k), 32'(bus.busy), 32'd1);
            if (k >= 2) begin
                chk($sformatf("burst%0d.m_valid", k), 32'(bus.m_valid), 32'd1);
                chk($sformatf("burst%0d.m_data", k), 32'(bus.m_data),
                    (((k - 2) / 4) % 2) != 0 ? 32'h80 : 32'h00);
            end
        end

        // Owner s1 streaming with downstream stalled for 3 cycles.
        do_reset();
        s1d = 8'h40;
        for (int k = 0; k < 12; k++) begin
            apply(1'b0, 8'h00, 1'b1, s1d, !(k >= 4 && k < 7));
            model_check($sformatf("stall%0d", k));
            model_step();
            if (acc1) s1d = s1d + 8'd1;
        end

        // Asynchronous reset in the middle of an s1 burst with a beat buffered.
        do_reset();
        for (int k = 0; k < 7; k++) begin
            apply(1'b1, 8'h10, 1'b1, 8'h20, 1'b1);
            model_check($sformatf("prerst%0d", k));
            model_step();
        end
        apply(1'b1, 8'h10, 1'b1, 8'h20, 1'b1);
        chk("prerst.sel", 32'(bus.sel), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.m_valid",  32'(bus.m_valid),  32'd0);
        chk("arst.sel",      32'(bus.sel),      32'd0);
        chk("arst.busy",     32'(bus.busy),     32'd0);
        chk("arst.s0_ready", 32'(bus.s0_ready), 32'd0);
        chk("arst.s1_ready", 32'(bus.s1_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        model_check("postrst0");
        model_step();
        apply(1'b1, 8'h10, 1'b1, 8'h20, 1'b1);
        chk("postrst.sel",  32'(bus.sel),  32'd0);
        chk("postrst.busy", 32'(bus.busy), 32'd1);

        // Randomized traffic against the reference model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            apply($urandom_range(0, 99) < 70, 8'($urandom),
                  $urandom_range(0, 99) < 60, 8'($urandom),
                  $urandom_range(0, 99) < 75);
            model_check("rand");
            model_step();
        end

`ifdef MUX_RR_ARBITER_STATS_EN
        @(negedge clk);
        chk("rand.gnt_cnt0", 32'(gnt_cnt0), 32'(st0));
        chk("rand.gnt_cnt1", 32'(gnt_cnt1), 32'(st1));
        do_reset();
        @(negedge clk);
        bus.s0_valid = 1'b1; bus.s0_data = 8'h5A;
        bus.m_ready  = 1'b1;
        repeat (70010) @(posedge clk);
        @(negedge clk);
        chk("sat.gnt_cnt0", 32'(gnt_cnt0), 32'hFFFF);
        chk("sat.gnt_cnt1", 32'(gnt_cnt1), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
